ioctl_upload_reader: RTL and testbench
======================================

Name: ioctl_upload_reader

Overview:
- Serves HPS upload requests (core → HPS direction of the ioctl channel) so the framework can save game work RAM, e.g. hiscore/NVRAM.
- Complements the existing download path, which carries ROM and DIP data from HPS into the core.
- Sits in emu beside hps_io. Pauses the game CPU, reads a dual-port RAM port one byte per ioctl_rd, and holds the framework off with ioctl_wait until each byte is valid.

Parameters:
- AW, 11, RAM address width in bits.
- SIZE, 2048, number of bytes exposed; must be ≤ 2^AW.
- UPLOAD_INDEX, 8'd4, ioctl_index value that selects this block.
- PAUSE_TIMEOUT, 4096, clk_sys cycles to wait for pause_ack before proceeding anyway.

Ports:
- clk_sys, input, 1, system clock (40 MHz); all logic is on its rising edge.
- reset, input, 1, synchronous, active-high.
- ioctl_upload, input, 1, upload session active (from hps_io).
- ioctl_index, input, 8, session index.
- ioctl_rd, input, 1, one-cycle read strobe for ioctl_addr.
- ioctl_addr, input, 25, byte address requested.
- ioctl_din, output, 8, byte returned to hps_io.
- ioctl_wait, output, 1, stalls hps_io while high.
- pause_req, output, 1, requests the game CPU to halt.
- pause_ack, input, 1, CPU has halted.
- ram_addr, output, AW, RAM read address.
- ram_rd, output, 1, RAM read enable.
- ram_q, input, 8, RAM data; valid 1 cycle after ram_rd.
- busy, output, 1, high in any state other than IDLE.
- overrun, output, 1, sticky error flag: an ioctl_rd arrived while a read was in flight.

Behaviour:
- **Session signal.** sel = ioctl_upload && ioctl_index==UPLOAD_INDEX.
- **Reset values.** ioctl_din=0, ioctl_wait=0, pause_req=0, ram_rd=0, ram_addr=0, busy=0, overrun=0. State goes to IDLE and the timeout counter clears.
- **State machine.** States are IDLE, PAUSE, READY, FETCH, CAPTURE, RELEASE.
- **IDLE:**
  - A rising edge of sel moves to PAUSE.
  - It also sets pause_req=1 and ioctl_wait=1, and clears the timeout counter and overrun.
- **PAUSE:**
  - pause_ack=1, or the timeout counter reaching PAUSE_TIMEOUT-1, moves to READY with ioctl_wait=0.
  - The counter saturates; it does not wrap.
- **READY, on ioctl_rd with ioctl_addr < SIZE:**
  - ram_addr=ioctl_addr[AW-1:0], ram_rd=1 for exactly 1 cycle, ioctl_wait=1.
  - Go to FETCH.
- **READY, on ioctl_rd with ioctl_addr ≥ SIZE:**
  - ioctl_din=8'hFF on the next cycle.
  - No RAM access and no wait assertion; stay in READY.
- **FETCH:** ram_rd=0; go to CAPTURE.
- **CAPTURE:** ioctl_din<=ram_q, ioctl_wait=0, then READY.
- **Latency.** ioctl_rd in cycle N gives ioctl_din valid and ioctl_wait low in cycle N+3.
- **ioctl_din hold.** ioctl_din holds its value between reads.
- **Overrun.** An ioctl_rd in FETCH or CAPTURE sets overrun. The request is dropped; the in-flight read completes normally.
- **sel falling in any non-IDLE state:**
  - Go to RELEASE on the next cycle and abort any in-flight read; ioctl_din is unchanged.
  - Force ram_rd=0 and ioctl_wait=0.
- **RELEASE:** pause_req=0, then IDLE after one cycle.
- **sel rising while in RELEASE:** wait for IDLE, then re-arm on the next cycle while sel is still high. The start is level-qualified, not missed.
- **Address range.** Addresses wrap only through the ≥ SIZE rule; ioctl_addr[24:AW] nonzero counts as ≥ SIZE.
- **Simultaneous events.** sel falling takes priority over ioctl_rd and pause_ack in the same cycle. reset takes priority over everything.

Optional Feature:
- Macro: UPLOAD_CHECKSUM_EN.
- **Defined:**
  - A 16-bit accumulator clears when PAUSE is entered.
  - In CAPTURE it adds the zero-extended ram_q, modulo 2^16.
  - Read at address SIZE returns the accumulator low byte; read at SIZE+1 returns the high byte. Both follow the no-RAM, next-cycle path; addresses > SIZE+1 return 8'hFF.
  - The accumulator is not updated by the checksum reads themselves.
- **Undefined:** addresses SIZE and SIZE+1 return 8'hFF like every other out-of-range address, and no accumulator logic is present.

Test Plan:
- **Pause handshake.** sel rises, pause_ack asserted 10 cycles later → pause_req=1 one cycle after the sel edge, then READY with ioctl_wait=0 on the ack+1 cycle.
- **Pause timeout.** pause_ack held at 0, PAUSE_TIMEOUT=16 → READY reached 16 cycles after PAUSE entry; pause_req stays 1.
- **Read latency.** RAM[0x123]=0x5A, ioctl_rd with addr 0x123 in cycle N → ram_rd pulse in N+1 with ram_addr=0x123; ioctl_wait high N+1..N+2; ioctl_din=0x5A and wait=0 in N+3.
- **Out of range.** ioctl_rd at addr 2048 and 0x10000 → ioctl_din=0xFF next cycle, ram_rd never asserted; with UPLOAD_CHECKSUM_EN, RAM 0..2047 all 0x01 read sequentially, then addr 2048→0x00, 2049→0x08.
- **Overrun.** Second ioctl_rd issued in FETCH → overrun=1 and only one ram_rd pulse; first byte still delivered; overrun clears at the next session start.
- **Abort.** sel drops during FETCH → RELEASE next cycle; ioctl_wait=0 and pause_req=0 within 2 cycles; ioctl_din keeps its prior value; a synchronous reset pulse mid-CAPTURE returns all outputs to reset values the next cycle.

Source files
------------

// File: rtl/ioctl_upload_reader.sv
// ioctl_upload_reader: serves HPS upload reads from a core RAM port while the game CPU is paused (optional UPLOAD_CHECKSUM_EN adds a checksum at SIZE/SIZE+1)
// Ports: clk_sys/reset (sync, active-high); ioctl_upload/ioctl_index/ioctl_rd/ioctl_addr from hps_io,
// ioctl_din/ioctl_wait back to it; pause_req/pause_ack CPU handshake; ram_addr/ram_rd/ram_q RAM read port
// (1-cycle latency); busy = not IDLE; overrun = sticky flag for reads dropped while one was in flight.
module ioctl_upload_reader #(
  parameter int         AW            = 11,
  parameter int         SIZE          = 2048,
  parameter logic [7:0] UPLOAD_INDEX  = 8'd4,
  parameter int         PAUSE_TIMEOUT = 4096
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_q,
  output logic          busy,
  output logic          overrun
);
  typedef enum logic [2:0] {IDLE, PAUSE, READY, FETCH, CAPTURE, RELEASE} state_t;
  localparam int CW = $clog2(PAUSE_TIMEOUT + 1);
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    din_n, oor_byte;
  logic [AW-1:0] addr_n;
  logic          wait_n, pause_n, rd_n, ovr_n, sel, in_range;
  assign sel      = ioctl_upload && ioctl_index == UPLOAD_INDEX;
  assign in_range = ioctl_addr < 25'(SIZE);
  assign busy     = state != IDLE;
`ifdef UPLOAD_CHECKSUM_EN
  logic [15:0] sum, sum_n;
  assign oor_byte = ioctl_addr == 25'(SIZE) ? sum[7:0] : ioctl_addr == 25'(SIZE + 1) ? sum[15:8] : 8'hFF;
`else
  assign oor_byte = 8'hFF;
`endif
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    din_n   = ioctl_din;
    wait_n  = ioctl_wait;
    pause_n = pause_req;
    rd_n    = 1'b0;
    addr_n  = ram_addr;
    ovr_n   = overrun;
`ifdef UPLOAD_CHECKSUM_EN
    sum_n   = sum;
`endif
    // losing sel beats any read or ack in the same cycle; an in-flight read is simply abandoned
    if (state != IDLE && state != RELEASE && !sel) begin
      state_n = RELEASE;
      wait_n  = 1'b0;
      pause_n = 1'b0;
    end else begin
      case (state)
        IDLE: if (sel) begin
          // level-qualified so a sel that re-rose during RELEASE still starts a session
          state_n = PAUSE;
          pause_n = 1'b1;
          wait_n  = 1'b1;
          cnt_n   = '0;
          ovr_n   = 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
          sum_n   = '0;
`endif
        end
        PAUSE: if (pause_ack || cnt == CW'(PAUSE_TIMEOUT - 1)) begin
          state_n = READY;
          wait_n  = 1'b0;
        end else cnt_n = cnt + 1'b1;
        READY: if (ioctl_rd) begin
          if (in_range) begin
            state_n = FETCH;
            addr_n  = ioctl_addr[AW-1:0];
            rd_n    = 1'b1;
            wait_n  = 1'b1;
          end else din_n = oor_byte;
        end
        FETCH: begin
          state_n = CAPTURE;
          ovr_n   = overrun | ioctl_rd;
        end
        CAPTURE: begin
          state_n = READY;
          din_n   = ram_q;
          wait_n  = 1'b0;
          ovr_n   = overrun | ioctl_rd;
`ifdef UPLOAD_CHECKSUM_EN
          sum_n   = sum + {8'h00, ram_q};
`endif
        end
        RELEASE: begin
          state_n = IDLE;
          pause_n = 1'b0;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      pause_req  <= 1'b0;
      ram_rd     <= 1'b0;
      ram_addr   <= '0;
      overrun    <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ioctl_din  <= din_n;
      ioctl_wait <= wait_n;
      pause_req  <= pause_n;
      ram_rd     <= rd_n;
      ram_addr   <= addr_n;
      overrun    <= ovr_n;
`ifdef UPLOAD_CHECKSUM_EN
      sum        <= sum_n;
`endif
    end
  end
endmodule

// File: tb/tb_ioctl_upload_reader.sv
// tb_ioctl_upload_reader: directed bench for ioctl_upload_reader
module tb_ioctl_upload_reader;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd4;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        pause_req;
  logic        pause_ack = 1'b0;
  logic [10:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_q = 8'h00;
  logic        busy;
  logic        overrun;
  logic [7:0]  mem [2048];
  int          rd_cnt = 0;
  int          checks = 0;
  int          errs = 0;

  ioctl_upload_reader #(.AW(11), .SIZE(2048), .UPLOAD_INDEX(8'd4), .PAUSE_TIMEOUT(16)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .pause_req(pause_req), .pause_ack(pause_ack), .ram_addr(ram_addr), .ram_rd(ram_rd),
    .ram_q(ram_q), .busy(busy), .overrun(overrun)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (ram_rd) begin
      ram_q  <= mem[ram_addr];
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    checks++; if (ioctl_din !== 8'h00) begin errs++; $display("FAIL reset_din got %h exp 00", ioctl_din); end
    checks++; if ({ioctl_wait, pause_req, ram_rd, busy, overrun} !== 5'b0) begin errs++; $display("FAIL reset_flags got %b exp 00000", {ioctl_wait, pause_req, ram_rd, busy, overrun}); end
    checks++; if (ram_addr !== 11'h000) begin errs++; $display("FAIL reset_addr got %h exp 000", ram_addr); end
  endtask

  task automatic test_pause_handshake;
    ioctl_upload = 1'b1;
    tick();
    checks++; if ({pause_req, ioctl_wait, busy} !== 3'b111) begin errs++; $display("FAIL hs_start got %b exp 111", {pause_req, ioctl_wait, busy}); end
    tick(9);
    checks++; if (ioctl_wait !== 1'b1) begin errs++; $display("FAIL hs_wait_hold got %b exp 1", ioctl_wait); end
    pause_ack = 1'b1;
    tick();
    pause_ack = 1'b0;
    checks++; if ({ioctl_wait, pause_req} !== 2'b01) begin errs++; $display("FAIL hs_ready got %b exp 01", {ioctl_wait, pause_req}); end
  endtask

  task automatic test_read_latency;
    int base;
    base = rd_cnt;
    ioctl_rd = 1'b1; ioctl_addr = 25'h123;
    tick();
    ioctl_rd = 1'b0;
    checks++; if ({ram_rd, ioctl_wait, ram_addr} !== {2'b11, 11'h123}) begin errs++; $display("FAIL lat_n1 got rd=%b wait=%b addr=%h exp 1 1 123", ram_rd, ioctl_wait, ram_addr); end
    tick();
    checks++; if ({ram_rd, ioctl_wait} !== 2'b01) begin errs++; $display("FAIL lat_n2 got %b exp 01", {ram_rd, ioctl_wait}); end
    tick();
    checks++; if ({ioctl_din, ioctl_wait} !== {8'h5A, 1'b0}) begin errs++; $display("FAIL lat_n3 got din=%h wait=%b exp 5a 0", ioctl_din, ioctl_wait); end
    checks++; if (rd_cnt - base !== 1) begin errs++; $display("FAIL lat_pulses got %0d exp 1", rd_cnt - base); end
  endtask

  task automatic oor_read(input logic [24:0] a, input logic [7:0] exp, input string nm);
    int base;
    base = rd_cnt;
    ioctl_rd = 1'b1; ioctl_addr = a;
    tick();
    ioctl_rd = 1'b0;
    checks++; if ({ioctl_din, ioctl_wait, ram_rd} !== {exp, 2'b00}) begin errs++; $display("FAIL %s got din=%h wait=%b rd=%b exp %h 0 0", nm, ioctl_din, ioctl_wait, ram_rd, exp); end
    tick();
    checks++; if (rd_cnt !== base) begin errs++; $display("FAIL %s_noram got %0d pulses exp 0", nm, rd_cnt - base); end
  endtask

  task automatic test_out_of_range;
    oor_read(25'd2048, 8'hFF, "oor_2048");
    ioctl_rd = 1'b1; ioctl_addr = 25'd5;
    tick();
    ioctl_rd = 1'b0;
    tick(2);
    checks++; if (ioctl_din !== 8'h39) begin errs++; $display("FAIL rd5 got %h exp 39", ioctl_din); end
    oor_read(25'h10000, 8'hFF, "oor_10000");
`ifdef UPLOAD_CHECKSUM_EN
    oor_read(25'd2048, 8'h93, "csum_lo");
    oor_read(25'd2049, 8'h00, "csum_hi");
    oor_read(25'd2050, 8'hFF, "oor_2050");
`else
    oor_read(25'd2049, 8'hFF, "oor_2049");
`endif
  endtask

  task automatic test_overrun;
    int base;
    base = rd_cnt;
    ioctl_rd = 1'b1; ioctl_addr = 25'h10;
    tick();
    ioctl_addr = 25'h20;
    tick();
    ioctl_rd = 1'b0;
    tick();
    checks++; if ({ioctl_din, ioctl_wait} !== {8'h2C, 1'b0}) begin errs++; $display("FAIL ovr_data got din=%h wait=%b exp 2c 0", ioctl_din, ioctl_wait); end
    checks++; if (overrun !== 1'b1) begin errs++; $display("FAIL ovr_flag got %b exp 1", overrun); end
    checks++; if (rd_cnt - base !== 1) begin errs++; $display("FAIL ovr_pulses got %0d exp 1", rd_cnt - base); end
  endtask

  task automatic test_abort;
    ioctl_rd = 1'b1; ioctl_addr = 25'h30;
    tick();
    ioctl_rd = 1'b0;
    ioctl_upload = 1'b0;
    tick();
    checks++; if ({busy, ioctl_wait, ram_rd, pause_req} !== 4'b1000) begin errs++; $display("FAIL abort_release got %b exp 1000", {busy, ioctl_wait, ram_rd, pause_req}); end
    checks++; if (ioctl_din !== 8'h2C) begin errs++; $display("FAIL abort_din got %h exp 2c", ioctl_din); end
    tick();
    checks++; if ({busy, overrun} !== 2'b01) begin errs++; $display("FAIL abort_idle got %b exp 01", {busy, overrun}); end
    ioctl_upload = 1'b1;
    tick();
    checks++; if ({pause_req, overrun} !== 2'b10) begin errs++; $display("FAIL restart got %b exp 10", {pause_req, overrun}); end
    pause_ack = 1'b1;
    tick();
    pause_ack = 1'b0;
    ioctl_rd = 1'b1; ioctl_addr = 25'h40;
    tick();
    ioctl_rd = 1'b0;
    tick();
    reset = 1'b1; ioctl_upload = 1'b0;
    tick();
    reset = 1'b0;
    checks++; if ({ioctl_din, ioctl_wait, pause_req, ram_rd, busy, overrun, ram_addr} !== 24'h0) begin errs++; $display("FAIL reset_capture got din=%h flags=%b addr=%h exp 0", ioctl_din, {ioctl_wait, pause_req, ram_rd, busy, overrun}, ram_addr); end
  endtask

  task automatic test_timeout;
    ioctl_upload = 1'b1;
    tick();
    tick(15);
    checks++; if ({ioctl_wait, busy} !== 2'b11) begin errs++; $display("FAIL to_15 got %b exp 11", {ioctl_wait, busy}); end
    tick();
    checks++; if ({ioctl_wait, pause_req} !== 2'b01) begin errs++; $display("FAIL to_16 got %b exp 01", {ioctl_wait, pause_req}); end
  endtask

  task automatic test_release_rearm;
    ioctl_upload = 1'b0;
    tick();
    ioctl_upload = 1'b1;
    tick();
    checks++; if ({busy, pause_req} !== 2'b00) begin errs++; $display("FAIL rearm_idle got %b exp 00", {busy, pause_req}); end
    tick();
    checks++; if ({busy, pause_req, ioctl_wait} !== 3'b111) begin errs++; $display("FAIL rearm_pause got %b exp 111", {busy, pause_req, ioctl_wait}); end
    ioctl_index = 8'd5;
    tick(2);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL index_drop got %b exp 0", busy); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[12'h123] = 8'h5A;
    test_reset;
    test_pause_handshake;
    test_read_latency;
    test_out_of_range;
    test_overrun;
    test_abort;
    test_timeout;
    test_release_rearm;
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
